// File: rtl/ifetch_prefetch_queue.sv
// ifetch_prefetch_queue: instruction-fetch front end feeding the IF/ID register.
// Issues sequential word fetches and tags each one with its address. In-order
// responses are buffered in a DEPTH-entry FIFO and presented as
// {instruction, pc+4}. A redirect flushes the FIFO and drains in-flight
// responses before fetching resumes at the new target.
// Optional build macro: IFQ_PERF_CNT_EN adds the perf_starve/perf_drop counters.
module ifetch_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   input  logic        stall,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc_plus4
`ifdef IFQ_PERF_CNT_EN
   ,
   output logic [31:0] perf_starve,
   output logic [15:0] perf_drop
`endif
);

   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = PW + 1;
   localparam int CW1 = CW + 1;
   localparam logic [CW:0] DEPTH_L = CW1'(DEPTH);

   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FLUSH} state_e;

   state_e          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   out_q, out_d;          // requests granted but not yet answered
   logic [CW-1:0]   count_q, count_d;      // FIFO occupancy
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   tag_wr_q, tag_wr_d;
   logic [PW-1:0]   tag_rd_q, tag_rd_d;

   logic [31:0]     instr_mem [DEPTH];
   logic [31:0]     pc4_mem   [DEPTH];
   logic [31:0]     tag_mem   [DEPTH];     // issued addresses, oldest at tag_rd_q

   logic            xfer;
   logic            resp_ok;
   logic            redir_act;
   logic            drop;
   logic            push;
   logic            pop;
   logic [CW:0]     inflight;

   // A response is only meaningful while something is outstanding; a stray
   // rvalid with nothing in flight is ignored entirely.
   assign xfer      = imem_req & imem_gnt;
   assign resp_ok   = imem_rvalid & (out_q != '0);
   assign redir_act = redirect & (state_q != S_BOOT);
   assign drop      = resp_ok & (redir_act | (state_q == S_FLUSH));
   assign push      = resp_ok & ~drop & (state_q == S_FETCH);
   assign pop       = out_valid & ~stall & ~redir_act;
   assign inflight  = {1'b0, count_q} + {1'b0, out_q};

   assign out_valid    = (count_q != '0);
   assign out_instr    = out_valid ? instr_mem[rd_ptr_q] : 32'h0;
   assign out_pc_plus4 = out_valid ? pc4_mem[rd_ptr_q]   : 32'h0;
   assign imem_addr    = fetch_pc_q;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_BOOT;
      else        state_q <= state_d;
   end

   // FSM next-state: a redirect only enters S_FLUSH if responses remain to drain
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_BOOT:  state_d = S_FETCH;
         S_FETCH: if (redirect) state_d = (out_d != '0) ? S_FLUSH : S_FETCH;
         S_FLUSH: if (out_d == '0) state_d = S_FETCH;
         default: state_d = S_BOOT;
      endcase
   end

   // FSM outputs: request only while the credit (FIFO + in-flight) allows
   always_comb begin
      imem_req = (state_q == S_FETCH) && (inflight < DEPTH_L);
   end

   // Next-state of fetch PC, credit counter, tag queue and FIFO pointers
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect)  fetch_pc_d = redirect_addr & 32'hFFFF_FFFC;
      else if (xfer) fetch_pc_d = fetch_pc_q + 32'd4;

      out_d    = out_q + CW'(xfer) - CW'(resp_ok);
      tag_wr_d = xfer    ? tag_wr_q + 1'b1 : tag_wr_q;
      tag_rd_d = resp_ok ? tag_rd_q + 1'b1 : tag_rd_q;

      if (redir_act) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         count_d  = count_q + CW'(push) - CW'(pop);
         wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
         rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      end
   end

   // Control registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         out_q      <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tag_wr_q   <= '0;
         tag_rd_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         out_q      <= out_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         tag_wr_q   <= tag_wr_d;
         tag_rd_q   <= tag_rd_d;
      end
   end

   // Storage: address tags on grant, {instr, pc+4} on an accepted response
   always_ff @(posedge clk) begin
      if (xfer) tag_mem[tag_wr_q] <= fetch_pc_q;
      if (push) begin
         instr_mem[wr_ptr_q] <= imem_rdata;
         pc4_mem[wr_ptr_q]   <= tag_mem[tag_rd_q] + 32'd4;
      end
   end

`ifdef IFQ_PERF_CNT_EN
   logic [31:0] perf_starve_q;
   logic [15:0] perf_drop_q;

   // Saturating counters: starved cycles after boot, and dropped responses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_starve_q <= '0;
         perf_drop_q   <= '0;
      end else begin
         if ((state_q != S_BOOT) && !out_valid && (perf_starve_q != 32'hFFFF_FFFF))
            perf_starve_q <= perf_starve_q + 32'd1;
         if (drop && (perf_drop_q != 16'hFFFF))
            perf_drop_q <= perf_drop_q + 16'd1;
      end
   end

   assign perf_starve = perf_starve_q;
   assign perf_drop   = perf_drop_q;
`endif

endmodule
